// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: core M-stage port, host port and memory port.
// The arbiter uses the slave modport; whatever drives the requesters and memory uses master.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_stall;
    logic [DW-1:0] core_rdata;
    logic          core_rvalid;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_stall, core_rdata, core_rvalid,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rdata, host_rvalid,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_stall, core_rdata, core_rvalid,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rdata, host_rvalid,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core M-stage and the host port.
// Core has priority; a saturating host wait counter forces a host grant after MAX_WAIT cycles.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_RD_WAIT = 1'b1;

    localparam int              WW       = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0]   WAIT_MAX = WW'(MAX_WAIT);
    localparam logic [2:0]      LAT_INIT = 3'(RD_LAT > 0 ? RD_LAT - 1 : 0);

    logic [0:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic [2:0]    lat_cnt_q, lat_cnt_d;
    logic [WW-1:0] host_wait_q, host_wait_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] core_rdata_q, core_rdata_d;
    logic [DW-1:0] host_rdata_q, host_rdata_d;

    logic          is_idle;
    logic          host_starved;
    logic          grant_host;
    logic          grant_core;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          rd_done;
    logic          issue_read;
    logic          core_rv;
    logic          host_rv;
    logic          core_stall;

    // The reset input is active-low; gating grants with it keeps every output quiet during reset.
    always_comb begin
        is_idle      = (state_q == S_IDLE);
        host_starved = bus.host_req && (host_wait_q == WAIT_MAX);
        grant_host   = reset && is_idle && (host_starved || (bus.host_req && !bus.core_req));
        grant_core   = reset && is_idle && bus.core_req && !host_starved;

        win_we    = grant_host ? bus.host_we    : bus.core_we;
        win_addr  = grant_host ? bus.host_addr  : bus.core_addr;
        win_wdata = grant_host ? bus.host_wdata : bus.core_wdata;

        rd_done    = !is_idle && (lat_cnt_q == 3'd0);
        issue_read = (grant_host || grant_core) && !win_we;

        core_rv = (grant_core && !bus.core_we && (RD_LAT == 0)) || (rd_done && !owner_q);
        host_rv = (grant_host && !bus.host_we && (RD_LAT == 0)) || (rd_done && owner_q);

        core_stall = reset && bus.core_req && !((grant_core && bus.core_we) || core_rv);

        state_d      = state_q;
        owner_d      = owner_q;
        lat_cnt_d    = lat_cnt_q;
        addr_d       = addr_q;
        host_wait_d  = host_wait_q;
        core_rdata_d = core_rv ? bus.mem_rdata : core_rdata_q;
        host_rdata_d = host_rv ? bus.mem_rdata : host_rdata_q;

        if (grant_host || grant_core) begin
            owner_d = grant_host;
            addr_d  = win_addr;
        end

        if (issue_read && (RD_LAT != 0)) begin
            state_d   = S_RD_WAIT;
            lat_cnt_d = LAT_INIT;
        end else if (rd_done) begin
            state_d = S_IDLE;
        end else if (!is_idle) begin
            lat_cnt_d = lat_cnt_q - 3'd1;
        end

        if (!bus.host_req || grant_host) begin
            host_wait_d = '0;
        end else if (host_wait_q != WAIT_MAX) begin
            host_wait_d = host_wait_q + WW'(1);
        end
    end

    // While a read is in flight the memory keeps seeing the latched address with writes blocked.
    assign bus.mem_we      = (grant_host || grant_core) && win_we;
    assign bus.mem_addr    = is_idle ? win_addr : addr_q;
    assign bus.mem_wdata   = win_wdata;
    assign bus.host_gnt    = grant_host;
    assign bus.core_stall  = core_stall;
    assign bus.core_rvalid = core_rv;
    assign bus.host_rvalid = host_rv;
    assign bus.core_rdata  = core_rv ? bus.mem_rdata : core_rdata_q;
    assign bus.host_rdata  = host_rv ? bus.mem_rdata : host_rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            lat_cnt_q    <= 3'd0;
            host_wait_q  <= '0;
            addr_q       <= '0;
            core_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            lat_cnt_q    <= lat_cnt_d;
            host_wait_q  <= host_wait_d;
            addr_q       <= addr_d;
            core_rdata_q <= core_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end
endmodule
